spot_locator: RTL and testbench
===============================

SPOT_LOCATOR -- requirements
Module: spot_locator

Interface
REQ-001 Parameter IMG_HDISP, 11'd1280, active pixels per line.
REQ-002 Parameter IMG_VDISP, 11'd720, active lines per frame.
REQ-003 Parameter BRIGHT_THRESH, 8'd200, minimum gray level counted as spot pixel.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  reset; synchronous and active-high.
REQ-006 per_frame_vsync  in  1  high = vertical blanking; falling edge = frame start, rising edge = frame end.
REQ-007 per_frame_href  in  1  line-active qualifier.
REQ-008 per_frame_clken  in  1  pixel strobe.
REQ-009 per_img_gray  in  8  luminance of current pixel.
REQ-010 max_x_1 / max_x_2  out  11  column of brightest pixel, left / right half.
REQ-011 y_avg_1 / y_avg_2  out  16  mean row of bright pixels, left / right half.
REQ-012 spot1_valid / spot2_valid  out  1  half contained at least one bright pixel in the last completed frame.
REQ-013 result_valid  out  1  one-cycle pulse when all outputs update.

Function
REQ-014 Pixel accepted when per_frame_clken && per_frame_href && !per_frame_vsync.
REQ-015 x_cnt increments per accepted pixel and wraps to 0 after IMG_HDISP-1, incrementing y_cnt; y_cnt wraps after IMG_VDISP-1; both clear on the vsync falling edge.
REQ-016 Half select: x_cnt < IMG_HDISP>>1 -> half 1, else half 2.
REQ-017 Per half, track peak gray and its x; update only on strictly greater value (first occurrence wins); peak initialises to 0, x to 0.
REQ-018 Per half, pixel with gray >= BRIGHT_THRESH adds y_cnt to 32-bit y_sum and 1 to 20-bit count.
REQ-019 vsync rising edge (registered edge detect, 1-cycle latency): snapshot sums, counts, peak x; clear live accumulators same cycle; FSM IDLE -> DIV1.
REQ-020 FSM states IDLE, DIV1, DIV2, DONE; DIV1 computes y_sum_1/count_1, DIV2 computes y_sum_2/count_2, DONE asserts result_valid 1 cycle then IDLE.
REQ-021 Division: unsigned restoring, 32-bit dividend, 20-bit divisor, exactly 32 cycles; quotient truncated to 16 bits (saturate to 16'hFFFF if upper bits nonzero).
REQ-022 Count zero: division skipped (1 cycle), y_avg = 0, max_x = 0, spotN_valid = 0.
REQ-023 Latency frame-end edge to result_valid: at most 1 + 33 + 33 + 1 = 68 cycles.
REQ-024 Outputs hold between result_valid pulses; all outputs update on the same cycle as result_valid.
REQ-025 Frame start during DIV1/DIV2: division continues on snapshot; new-frame accumulation proceeds independently.
REQ-026 vsync rising edge while not IDLE: edge ignored, that frame's result dropped, live accumulators still cleared.
REQ-027 Accumulators saturate, never wrap.

Reset
REQ-028 rst clears counters, accumulators, snapshots, FSM to IDLE, edge detector to 0.
REQ-029 Reset values: max_x_* = 0, y_avg_* = 0, spot*_valid = 0, result_valid = 0.
REQ-030 rst mid-division aborts; no result_valid pulse follows until a full frame completes.

Structure
REQ-031 FSM state encoding and accumulator width constants live in shared package spot_pkg.
REQ-032 Divider is a sub-module seq_divider (start/busy/done, 32/20-bit operands), instanced once and shared by DIV1/DIV2.

Verification (bench IMG_HDISP=64, IMG_VDISP=32, BRIGHT_THRESH=200)
REQ-033 Frame all gray 10 -> result_valid once, all outputs 0, valid flags 0.
REQ-034 Single pixel 255 at (x=5,y=7), rest 0 -> max_x_1=5, y_avg_1=7, spot1_valid=1, spot2_valid=0.
REQ-035 Bright 220 at rows 10..13, x=40, plus 250 at (45,20) -> max_x_2=45, y_avg_2=(10+11+12+13+20)/5=13.
REQ-036 Two equal 230 pixels at x=3 and x=9, same half -> max_x_1=3.
REQ-037 Frames back-to-back with 70-cycle blanking -> each frame yields one result_valid within 68 cycles of vsync rise; second result independent of first.
REQ-038 rst asserted 10 cycles into DIV1 -> outputs 0, no result_valid until next complete frame.

Source files
------------

// File: rtl/spot_pkg.sv
// Shared types and widths for the spot locator: FSM encoding, accumulator widths,
// per-half accumulator payload and quotient saturation helper.
package spot_pkg;

   localparam int unsigned X_W    = 11;
   localparam int unsigned GRAY_W = 8;
   localparam int unsigned SUM_W  = 32;
   localparam int unsigned CNT_W  = 20;
   localparam int unsigned AVG_W  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV1 = 2'd1,
      DIV2 = 2'd2,
      DONE = 2'd3
   } spot_state_e;

   typedef struct packed {
      logic [SUM_W-1:0] y_sum;
      logic [CNT_W-1:0] count;
      logic [X_W-1:0]   peak_x;
   } half_acc_t;

   // Clamp a full-width quotient into the published average width.
   function automatic logic [AVG_W-1:0] sat_avg(input logic [SUM_W-1:0] q);
      return (|q[SUM_W-1:AVG_W]) ? '1 : q[AVG_W-1:0];
   endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, zero divisor returns 0 after one cycle.
module seq_divider
   import spot_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [SUM_W-1:0] dividend,
   input  logic [CNT_W-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [SUM_W-1:0] quotient
);

   localparam int unsigned STEP_W = $clog2(SUM_W + 1);

   logic [CNT_W-1:0]  rem_q;
   logic [CNT_W-1:0]  dvsr_q;
   logic [STEP_W-1:0] steps_q;
   logic [CNT_W:0]    shifted_c;
   logic [CNT_W:0]    trial_c;
   logic              borrow_c;

   // Remainder stays below the divisor, so bit CNT_W of the trial is the borrow.
   always_comb begin
      shifted_c = {rem_q, quotient[SUM_W-1]};
      trial_c   = shifted_c - {1'b0, dvsr_q};
      borrow_c  = trial_c[CNT_W];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q    <= '0;
         dvsr_q   <= '0;
         steps_q  <= '0;
         quotient <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start && !busy) begin
            rem_q  <= '0;
            dvsr_q <= divisor;
            if (divisor == '0) begin
               quotient <= '0;
               done     <= 1'b1;
            end else begin
               quotient <= dividend;
               steps_q  <= STEP_W'(SUM_W);
               busy     <= 1'b1;
            end
         end else if (busy) begin
            rem_q    <= borrow_c ? shifted_c[CNT_W-1:0] : trial_c[CNT_W-1:0];
            quotient <= {quotient[SUM_W-2:0], ~borrow_c};
            steps_q  <= steps_q - 1'b1;
            if (steps_q == STEP_W'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/spot_locator.sv
// Locates the brightest column and mean bright row in the left and right image halves,
// publishing one result set per completed frame.
module spot_locator
   import spot_pkg::*;
#(
   parameter logic [X_W-1:0]    IMG_HDISP     = 11'd1280,
   parameter logic [X_W-1:0]    IMG_VDISP     = 11'd720,
   parameter logic [GRAY_W-1:0] BRIGHT_THRESH = 8'd200
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              per_frame_vsync,
   input  logic              per_frame_href,
   input  logic              per_frame_clken,
   input  logic [GRAY_W-1:0] per_img_gray,
   output logic [X_W-1:0]    max_x_1,
   output logic [X_W-1:0]    max_x_2,
   output logic [AVG_W-1:0]  y_avg_1,
   output logic [AVG_W-1:0]  y_avg_2,
   output logic              spot1_valid,
   output logic              spot2_valid,
   output logic              result_valid
);

   localparam logic [X_W-1:0] X_LAST = IMG_HDISP - 1'b1;
   localparam logic [X_W-1:0] Y_LAST = IMG_VDISP - 1'b1;
   localparam logic [X_W-1:0] HALF_X = IMG_HDISP >> 1;

   logic              vsync_d_q, rise_q, frame_seen_q;
   logic              rise_c, fall_c, accept_c, bright_c, half2_c, launch_c;
   logic [X_W-1:0]    x_cnt_q, y_cnt_q, cur_x_c, cur_y_c;
   logic [1:0]        hit_c;
   half_acc_t         acc_q [2];
   logic [GRAY_W-1:0] peak_q [2];
   logic [SUM_W:0]    sum_ext_c [2];
   half_acc_t         snap2_q;
   logic [X_W-1:0]    snap_x1_q;
   logic              snap_v1_q;
   logic [AVG_W-1:0]  avg1_q, avg2_q;
   spot_state_e       state_q, state_d;
   logic              div_start_c, div_busy, div_done, cap1_c, cap2_c, publish_c;
   logic [SUM_W-1:0]  div_dividend_c, div_q;
   logic [CNT_W-1:0]  div_divisor_c;

   // A falling vsync restarts the raster at this very pixel, so coordinates are muxed.
   always_comb begin
      rise_c    = per_frame_vsync & ~vsync_d_q;
      fall_c    = ~per_frame_vsync & vsync_d_q;
      accept_c  = per_frame_clken & per_frame_href & ~per_frame_vsync;
      bright_c  = per_img_gray >= BRIGHT_THRESH;
      cur_x_c   = fall_c ? '0 : x_cnt_q;
      cur_y_c   = fall_c ? '0 : y_cnt_q;
      half2_c   = cur_x_c >= HALF_X;
      hit_c[0]  = accept_c & ~half2_c;
      hit_c[1]  = accept_c & half2_c;
      launch_c  = rise_q && frame_seen_q && (state_q == IDLE) && !div_busy;
      for (int h = 0; h < 2; h++) begin
         sum_ext_c[h] = {1'b0, acc_q[h].y_sum} + (SUM_W+1)'(cur_y_c);
      end
   end

   // frame_seen gates launches so a reset inside blanking cannot fake a frame end.
   always_ff @(posedge clk) begin
      if (rst) begin
         vsync_d_q    <= 1'b0;
         rise_q       <= 1'b0;
         frame_seen_q <= 1'b0;
      end else begin
         vsync_d_q <= per_frame_vsync;
         rise_q    <= rise_c;
         if (fall_c)
            frame_seen_q <= 1'b1;
         else if (rise_q)
            frame_seen_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_cnt_q <= '0;
         y_cnt_q <= '0;
      end else if (accept_c) begin
         if (cur_x_c == X_LAST) begin
            x_cnt_q <= '0;
            y_cnt_q <= (cur_y_c == Y_LAST) ? '0 : cur_y_c + 1'b1;
         end else begin
            x_cnt_q <= cur_x_c + 1'b1;
            y_cnt_q <= cur_y_c;
         end
      end else if (fall_c) begin
         x_cnt_q <= '0;
         y_cnt_q <= '0;
      end
   end

   // Live per-half accumulators; cleared on every frame end whether or not it launches.
   always_ff @(posedge clk) begin
      for (int h = 0; h < 2; h++) begin
         if (rst || rise_q) begin
            acc_q[h]  <= '0;
            peak_q[h] <= '0;
         end else if (hit_c[h]) begin
            if (per_img_gray > peak_q[h]) begin
               peak_q[h]       <= per_img_gray;
               acc_q[h].peak_x <= cur_x_c;
            end
            if (bright_c) begin
               acc_q[h].y_sum <= sum_ext_c[h][SUM_W] ? '1 : sum_ext_c[h][SUM_W-1:0];
               if (!(&acc_q[h].count))
                  acc_q[h].count <= acc_q[h].count + 1'b1;
            end
         end
      end
   end

   // Half 1 goes straight into the divider at launch; the rest is held for later.
   always_ff @(posedge clk) begin
      if (rst) begin
         snap2_q   <= '0;
         snap_x1_q <= '0;
         snap_v1_q <= 1'b0;
      end else if (launch_c) begin
         snap2_q.y_sum  <= acc_q[1].y_sum;
         snap2_q.count  <= acc_q[1].count;
         snap2_q.peak_x <= (|acc_q[1].count) ? acc_q[1].peak_x : '0;
         snap_x1_q      <= (|acc_q[0].count) ? acc_q[0].peak_x : '0;
         snap_v1_q      <= |acc_q[0].count;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (launch_c) state_d = DIV1;
         DIV1:    if (div_done) state_d = DIV2;
         DIV2:    if (div_done) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      div_start_c    = 1'b0;
      div_dividend_c = '0;
      div_divisor_c  = '0;
      cap1_c         = 1'b0;
      cap2_c         = 1'b0;
      publish_c      = 1'b0;
      unique case (state_q)
         IDLE: if (launch_c) begin
            div_start_c    = 1'b1;
            div_dividend_c = acc_q[0].y_sum;
            div_divisor_c  = acc_q[0].count;
         end
         DIV1: if (div_done) begin
            cap1_c         = 1'b1;
            div_start_c    = 1'b1;
            div_dividend_c = snap2_q.y_sum;
            div_divisor_c  = snap2_q.count;
         end
         DIV2:    cap2_c    = div_done;
         DONE:    publish_c = 1'b1;
         default: ;
      endcase
   end

   seq_divider u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start_c),
      .dividend (div_dividend_c),
      .divisor  (div_divisor_c),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         avg1_q       <= '0;
         avg2_q       <= '0;
         max_x_1      <= '0;
         max_x_2      <= '0;
         y_avg_1      <= '0;
         y_avg_2      <= '0;
         spot1_valid  <= 1'b0;
         spot2_valid  <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         result_valid <= publish_c;
         if (cap1_c) avg1_q <= sat_avg(div_q);
         if (cap2_c) avg2_q <= sat_avg(div_q);
         if (publish_c) begin
            y_avg_1     <= avg1_q;
            y_avg_2     <= avg2_q;
            max_x_1     <= snap_x1_q;
            max_x_2     <= snap2_q.peak_x;
            spot1_valid <= snap_v1_q;
            spot2_valid <= |snap2_q.count;
         end
      end
   end

endmodule

// File: tb/tb_spot_locator.sv
// Scoreboard bench for spot_locator: frames are modelled as whole images and the
// expected per-half results are queued at frame end for an independent monitor.
module tb_spot_locator;

   localparam int HD      = 64;
   localparam int VD      = 32;
   localparam int TH      = 200;
   localparam int HALF    = HD / 2;
   localparam int MAX_LAT = 68;

   logic        clk = 1'b0;
   logic        rst, vsync, href, clken;
   logic [7:0]  gray;
   logic [10:0] max_x_1, max_x_2;
   logic [15:0] y_avg_1, y_avg_2;
   logic        spot1_valid, spot2_valid, result_valid;

   typedef struct {
      int x1; int x2; int a1; int a2; int v1; int v2; int rise_cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   mon_lat;
   int   img [VD][HD];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   spot_locator #(
      .IMG_HDISP     (11'd64),
      .IMG_VDISP     (11'd32),
      .BRIGHT_THRESH (8'd200)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .per_frame_vsync (vsync),
      .per_frame_href  (href),
      .per_frame_clken (clken),
      .per_img_gray    (gray),
      .max_x_1         (max_x_1),
      .max_x_2         (max_x_2),
      .y_avg_1         (y_avg_1),
      .y_avg_2         (y_avg_2),
      .spot1_valid     (spot1_valid),
      .spot2_valid     (spot2_valid),
      .result_valid    (result_valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Whole-image reference: first raster occurrence of the strict maximum, mean bright row.
   function automatic exp_t model();
      exp_t e;
      int peak[2] = '{0, 0};
      int px[2]   = '{0, 0};
      int sum[2]  = '{0, 0};
      int cnt[2]  = '{0, 0};
      int h;
      for (int y = 0; y < VD; y++)
         for (int x = 0; x < HD; x++) begin
            h = (x < HALF) ? 0 : 1;
            if (img[y][x] > peak[h]) begin peak[h] = img[y][x]; px[h] = x; end
            if (img[y][x] >= TH) begin sum[h] += y; cnt[h]++; end
         end
      e.x1 = (cnt[0] != 0) ? px[0] : 0;
      e.x2 = (cnt[1] != 0) ? px[1] : 0;
      e.a1 = (cnt[0] != 0) ? sum[0] / cnt[0] : 0;
      e.a2 = (cnt[1] != 0) ? sum[1] / cnt[1] : 0;
      e.v1 = (cnt[0] != 0) ? 1 : 0;
      e.v2 = (cnt[1] != 0) ? 1 : 0;
      e.rise_cyc = 0;
      return e;
   endfunction

   always @(negedge clk) begin
      if (result_valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: result_valid=1 with no completed frame pending");
         end else begin
            mon_e = sb.pop_front();
            check("max_x_1", max_x_1, mon_e.x1);
            check("max_x_2", max_x_2, mon_e.x2);
            check("y_avg_1", y_avg_1, mon_e.a1);
            check("y_avg_2", y_avg_2, mon_e.a2);
            check("spot1_valid", spot1_valid, mon_e.v1);
            check("spot2_valid", spot2_valid, mon_e.v2);
            mon_lat = cyc - mon_e.rise_cyc - 1;
            n_checks++;
            if (mon_lat > MAX_LAT) begin
               n_fail++;
               $display("FAIL latency: got %0d cycles limit %0d", mon_lat, MAX_LAT);
            end
         end
      end
   end

   task automatic step(input logic v, input logic h, input logic c, input logic [7:0] g);
      vsync = v; href = h; clken = c; gray = g;
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input int v);
      for (int y = 0; y < VD; y++)
         for (int x = 0; x < HD; x++)
            img[y][x] = v;
   endtask

   task automatic fill_random();
      for (int y = 0; y < VD; y++)
         for (int x = 0; x < HD; x++)
            img[y][x] = ($urandom_range(0, 15) == 0) ? $urandom_range(150, 255)
                                                      : $urandom_range(0, 199);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_max_x_1"}, max_x_1, 0);
      check({tag, "_max_x_2"}, max_x_2, 0);
      check({tag, "_y_avg_1"}, y_avg_1, 0);
      check({tag, "_y_avg_2"}, y_avg_2, 0);
      check({tag, "_spot1_valid"}, spot1_valid, 0);
      check({tag, "_spot2_valid"}, spot2_valid, 0);
      check({tag, "_result_valid"}, result_valid, 0);
   endtask

   // Streams img with random clken gaps and junk outside href, then raises vsync.
   task automatic send_frame(input int blank, input bit push);
      exp_t e;
      e = model();
      repeat (4) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
      for (int y = 0; y < VD; y++) begin
         for (int x = 0; x < HD; x++) begin
            while ($urandom_range(0, 7) == 0) step(1'b0, 1'b1, 1'b0, 8'($urandom));
            step(1'b0, 1'b1, 1'b1, 8'(img[y][x]));
         end
         repeat (3) step(1'b0, 1'b0, 1'b1, 8'($urandom));
      end
      e.rise_cyc = cyc;
      if (push) sb.push_back(e);
      repeat (blank) step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
   endtask

   initial begin
      rst = 1'b1; vsync = 1'b1; href = 1'b0; clken = 1'b0; gray = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) step(1'b1, 1'b0, 1'b0, 8'd0);
      check_outputs_zero("reset");

      fill(10);
      send_frame(80, 1'b1);

      fill(0);
      img[7][5] = 255;
      send_frame(80, 1'b1);

      fill(0);
      for (int y = 10; y <= 13; y++) img[y][40] = 220;
      img[20][45] = 250;
      send_frame(80, 1'b1);

      fill(0);
      img[4][3] = 230;
      img[4][9] = 230;
      send_frame(80, 1'b1);

      for (int f = 0; f < 2; f++) begin
         fill_random();
         send_frame(70, 1'b1);
      end

      // Next frame starts while the previous result is still dividing.
      fill_random();
      send_frame(20, 1'b1);

      // A short frame ends while dividing: it must be dropped without disturbing the next one.
      fill_random();
      send_frame(10, 1'b1);
      repeat (3) step(1'b0, 1'b0, 1'b0, 8'd0);
      repeat (5) step(1'b0, 1'b1, 1'b1, 8'd255);
      repeat (80) step(1'b1, 1'b0, 1'b0, 8'd0);

      fill_random();
      send_frame(80, 1'b1);

      // Reset lands inside the first division of a completed frame.
      fill_random();
      send_frame(12, 1'b0);
      rst = 1'b1;
      repeat (2) step(1'b1, 1'b0, 1'b0, 8'd0);
      rst = 1'b0;
      step(1'b1, 1'b0, 1'b0, 8'd0);
      check_outputs_zero("mid_div_reset");
      repeat (100) step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));

      fill_random();
      send_frame(80, 1'b1);

      for (int i = 0; i < 200 && sb.size() != 0; i++) step(1'b1, 1'b0, 1'b0, 8'd0);
      check("scoreboard_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
